irq_controller_multi: RTL and testbench

Parametrised successor to the single-enable IRQ controller on the 68000 E-clock peripheral bus (CIA-style register window, `rs[3:0]`, `data[7:0]`). Collects up to 7 interrupt sources and stores them in pending flags. Each source is level- or edge-sensitive. A CIA-style ICR with set/clear writes masks the sources; the combined result drives one active-high interrupt request. Sits beside the existing register blocks, decoded by the same `_cs`.

---
 rtl/irq_controller_multi_pkg.sv | 18 +
 rtl/irq_controller_multi_sync_edge.sv | 36 +++
 rtl/irq_controller_multi.sv | 138 +++++++++++++
 tb/tb_irq_controller_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_multi_pkg.sv
// Shared constants and bus-operation type for the multi-source IRQ controller.
package irq_pkg;

  localparam int         MAX_SRC     = 7;
  localparam int         SETCLR_BIT  = 7;
  localparam int         ANY_BIT     = 7;
  localparam logic [3:0] ICR_RS_DEF  = 4'hD;
  localparam logic [3:0] PEND_RS_DEF = 4'hC;

  // One decoded E-clock bus event, already qualified by chip select.
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [3:0] rs;
    logic [7:0] wdata;
  } bus_op_t;

endpackage

// File: rtl/irq_controller_multi_sync_edge.sv
// Two-flop synchroniser with single-cycle rise/fall pulses on the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/irq_controller_multi.sv
// CIA-style interrupt controller: per-source edge/level pending flags, set/clear mask,
// snapshot-and-clear ICR read, and a single registered active-high irq.
module irq_controller_multi
  import irq_pkg::*;
#(
  parameter int               NUM_SRC   = 6,
  parameter logic [MAX_SRC-1:0] EDGE_MASK = 7'b0000011,
  parameter logic [3:0]       ICR_RS    = ICR_RS_DEF,
  parameter logic [3:0]       PEND_RS   = PEND_RS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               r_w,
  input  logic               _cs,
  input  logic               e,
  input  logic [3:0]         rs,
  inout  wire  [7:0]         data,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq
);

  logic               e_q, e_rise, e_fall;
  logic [NUM_SRC-1:0] src_q, src_rise, src_fall;

  sync_edge u_e_sync (
    .clk  (clk),
    .reset(reset),
    .d    (e),
    .q    (e_q),
    .rise (e_rise),
    .fall (e_fall)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sync_edge u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (irq_src[i]),
      .q    (src_q[i]),
      .rise (src_rise[i]),
      .fall (src_fall[i])
    );
  end

  logic [1:0]         warm_q, warm_d;
  logic               arm_q, arm_d;
  logic               rd_icr_q, rd_icr_d;
  logic [NUM_SRC-1:0] snap_q, snap_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic               irq_q, irq_d;

  bus_op_t            op;
  logic               icr_wr, pend_wr, icr_rd, cyc_end;
  logic [NUM_SRC-1:0] wbits, hw_set, sw_set, clr;
  logic               setop;

  // A reset that lands mid-cycle leaves e high; the bus stays disarmed until the
  // synchronised e has been seen low, so the aborted cycle's edges are ignored.
  always_comb begin
    warm_d = {warm_q[0], 1'b1};
    arm_d  = arm_q | (warm_q[1] & ~e_q);
  end

  always_comb begin
    op.wr    = arm_q & e_fall & ~_cs & ~r_w;
    op.rd    = arm_q & e_rise & ~_cs & r_w;
    op.rs    = rs;
    op.wdata = data;
    icr_wr   = op.wr && (op.rs == ICR_RS);
    pend_wr  = op.wr && (op.rs == PEND_RS);
    icr_rd   = op.rd && (op.rs == ICR_RS);
    cyc_end  = arm_q & e_fall;
    wbits    = op.wdata[NUM_SRC-1:0];
    setop    = op.wdata[SETCLR_BIT];
  end

  always_comb begin
    hw_set = (src_rise & EDGE_MASK[NUM_SRC-1:0]) | (src_q & ~EDGE_MASK[NUM_SRC-1:0]);
    sw_set = (pend_wr && setop) ? wbits : '0;
    clr    = (pend_wr && !setop) ? wbits : '0;
    if (cyc_end && rd_icr_q) clr = clr | snap_q;
    // Sets are OR'd in after the clear so a same-cycle event is never lost.
    pend_d = (pend_q & ~clr) | hw_set | sw_set;

    mask_d = mask_q;
    if (icr_wr) mask_d = setop ? (mask_q | wbits) : (mask_q & ~wbits);

    snap_d   = icr_rd ? pend_q : snap_q;
    rd_icr_d = icr_rd ? 1'b1 : (cyc_end ? 1'b0 : rd_icr_q);
    irq_d    = |(pend_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q   <= '0;
      arm_q    <= 1'b0;
      rd_icr_q <= 1'b0;
      snap_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      arm_q    <= arm_d;
      rd_icr_q <= rd_icr_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

  logic [MAX_SRC-1:0] snap_x, pend_x;
  logic [7:0]         rd_data;

  always_comb begin
    snap_x = '0;
    pend_x = '0;
    snap_x[NUM_SRC-1:0] = snap_q;
    pend_x[NUM_SRC-1:0] = pend_q;
    rd_data = 8'h00;
    if (rs == ICR_RS) begin
      rd_data          = {1'b0, snap_x};
      rd_data[ANY_BIT] = |(snap_q & mask_q);
    end else if (rs == PEND_RS) begin
      rd_data = {1'b0, pend_x};
    end
  end

  assign data = (~_cs & r_w & e & ~reset) ? rd_data : 8'bz;

  logic unused_bits;
  assign unused_bits = ^{src_fall, op.wdata};

endmodule

// File: tb/tb_irq_controller_multi.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor compares on each check strobe.
module tb_irq_controller_multi;

  localparam int         NUM_SRC = 6;
  localparam logic [5:0] EDGE    = 6'b000011;
  localparam logic [3:0] A_ICR   = 4'hD;
  localparam logic [3:0] A_PEND  = 4'hC;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               r_w = 1'b1;
  logic               cs_n = 1'b1;
  logic               e = 1'b0;
  logic [3:0]         rs = 4'h0;
  logic [NUM_SRC-1:0] irq_src = '0;
  logic               irq;
  wire  [7:0]         data;
  logic               tb_drv = 1'b0;
  logic [7:0]         tb_dout = 8'h00;

  assign data = tb_drv ? tb_dout : 8'bz;
  always #5 clk = ~clk;

  irq_controller_multi dut (
    .clk    (clk),
    .reset  (reset),
    .r_w    (r_w),
    ._cs    (cs_n),
    .e      (e),
    .rs     (rs),
    .data   (data),
    .irq_src(irq_src),
    .irq    (irq)
  );

  // Reference model: transaction-level pending/mask bit vectors.
  logic [5:0] m_mask = '0;
  logic [5:0] m_pend = '0;

  typedef struct {
    int         kind;   // 0 data value, 1 irq, 2 data high-Z
    string      name;
    logic [7:0] exp;
  } chk_t;

  chk_t sb[$];
  event chk_ev;
  int   vectors = 0;
  int   miscompares = 0;

  initial forever begin : monitor
    chk_t c;
    @(chk_ev);
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_underflow: strobe with no expectation");
    end else begin
      c = sb.pop_front();
      vectors++;
      case (c.kind)
        0: if (data !== c.exp) begin
             miscompares++;
             $display("FAIL %s: data got %h want %h", c.name, data, c.exp);
           end
        1: if (irq !== c.exp[0]) begin
             miscompares++;
             $display("FAIL %s: irq got %b want %b", c.name, irq, c.exp[0]);
           end
        default: if (data !== 8'bz) begin
             miscompares++;
             $display("FAIL %s: data got %h want zz", c.name, data);
           end
      endcase
    end
  end

  task automatic expect_chk(input int kind, input string nm, input logic [7:0] exp);
    chk_t c;
    @(negedge clk);
    c.kind = kind; c.name = nm; c.exp = exp;
    sb.push_back(c);
    -> chk_ev;
    #1;
  endtask

  function automatic logic [5:0] setclr(input logic [5:0] cur, input logic [7:0] d);
    return d[7] ? (cur | d[5:0]) : (cur & ~d[5:0]);
  endfunction

  function automatic logic [7:0] m_icr();
    logic [7:0] r;
    r    = {2'b00, m_pend};
    r[7] = |(m_pend & m_mask);
    return r;
  endfunction

  task automatic settle(input string nm);
    repeat (6) @(posedge clk);
    m_pend = m_pend | (irq_src & ~EDGE);
    expect_chk(1, nm, {7'b0, |(m_pend & m_mask)});
  endtask

  task automatic bus(input bit wr, input logic [3:0] a, input logic [7:0] wd,
                     input logic [7:0] exp, input string nm, input logic [5:0] mid);
    @(posedge clk); #1;
    cs_n = 1'b0; r_w = !wr; rs = a; tb_dout = wd; tb_drv = wr;
    repeat (2) @(posedge clk); #1 e = 1'b1;
    repeat (4) @(posedge clk);
    if (mid != 0) begin
      #1 irq_src = irq_src | mid;
      repeat (3) @(posedge clk);
      #1 irq_src = irq_src & ~mid;
    end
    repeat (2) @(posedge clk);
    if (!wr) expect_chk(0, nm, exp);
    @(posedge clk); #1 e = 1'b0;
    repeat (5) @(posedge clk);
    #1 cs_n = 1'b1; tb_drv = 1'b0; r_w = 1'b1;
  endtask

  task automatic wr_icr(input logic [7:0] d);
    bus(1'b1, A_ICR, d, 8'h00, "", '0);
    m_mask = setclr(m_mask, d);
    settle("irq_after_icr_wr");
  endtask

  task automatic wr_pend(input logic [7:0] d);
    bus(1'b1, A_PEND, d, 8'h00, "", '0);
    m_pend = setclr(m_pend, d);
    settle("irq_after_pend_wr");
  endtask

  task automatic rd_icr(input string nm, input logic [5:0] mid);
    logic [7:0] exp;
    exp = m_icr();
    bus(1'b0, A_ICR, 8'h00, exp, nm, mid);
    m_pend = (m_pend | mid) & ~exp[5:0];
    settle("irq_after_icr_rd");
  endtask

  task automatic rd_pend(input string nm);
    bus(1'b0, A_PEND, 8'h00, {2'b00, m_pend}, nm, '0);
    settle("irq_after_pend_rd");
  endtask

  task automatic pulse_edge(input logic [5:0] bits);
    @(posedge clk); #1 irq_src = irq_src | bits;
    repeat (3) @(posedge clk); #1 irq_src = irq_src & ~bits;
    m_pend = m_pend | bits;
    settle("irq_after_pulse");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    expect_chk(1, "reset_irq", 8'h00);
    expect_chk(2, "reset_dataz", 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);

    // 1: edge source with latency boundary
    wr_icr(8'h81);
    @(posedge clk); #1 irq_src[0] = 1'b1;
    repeat (3) @(posedge clk);
    expect_chk(1, "lat_3clk", 8'h00);
    @(posedge clk);
    expect_chk(1, "lat_4clk", 8'h01);
    irq_src[0] = 1'b0;
    m_pend = m_pend | 6'h01;
    settle("t1_irq");
    rd_icr("t1_icr", '0);
    rd_pend("t1_pend");

    // 2: masked source
    wr_icr(8'h01);
    pulse_edge(6'h01);
    rd_pend("t2_pend");
    wr_icr(8'h81);

    // 3: level source
    wr_pend(8'h01);
    irq_src[2] = 1'b1;
    settle("t3_lvl_on");
    wr_icr(8'h84);
    rd_icr("t3_icr", '0);
    rd_pend("t3_pend");
    irq_src[2] = 1'b0;
    settle("t3_lvl_off");
    rd_icr("t3_icr2", '0);

    // 4: event between snapshot and clear survives
    rd_icr("t4_icr", 6'h02);
    rd_pend("t4_pend");

    // 5: software trigger, ignored high bits
    wr_icr(8'h90);
    wr_pend(8'h90);
    wr_pend(8'h10);
    wr_icr(8'hC0);
    wr_pend(8'h90);
    wr_icr(8'h40);
    wr_pend(8'h12);

    // 6: reset during a bus cycle
    irq_src = '0;
    settle("t6_pre");
    @(posedge clk); #1;
    cs_n = 1'b0; r_w = 1'b1; rs = A_ICR; e = 1'b1;
    repeat (2) @(posedge clk); #1 reset = 1'b1;
    expect_chk(2, "t6_rst_dataz", 8'h00);
    expect_chk(1, "t6_rst_irq", 8'h00);
    m_mask = '0; m_pend = '0;
    r_w = 1'b0; tb_dout = 8'h81; tb_drv = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk); #1 e = 1'b0;
    repeat (5) @(posedge clk); #1 cs_n = 1'b1; tb_drv = 1'b0; r_w = 1'b1;
    settle("t6_irq");
    rd_icr("t6_icr", '0);
    wr_pend(8'h81);
    rd_icr("t6_icr_mask", '0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0: wr_icr(8'($urandom));
        1: wr_pend(8'($urandom));
        2: rd_icr("rnd_icr", ($urandom_range(0, 3) == 0) ? (EDGE & 6'($urandom)) : 6'h00);
        3: rd_pend("rnd_pend");
        4: pulse_edge(EDGE & 6'($urandom));
        5: begin
             int idx;
             idx = $urandom_range(2, 5);
             irq_src[idx] = ~irq_src[idx];
             settle("rnd_lvl");
           end
        default: begin
             logic [3:0] a;
             a = 4'($urandom_range(0, 11));
             bus(1'b1, a, 8'($urandom), 8'h00, "", '0);
             bus(1'b0, a, 8'h00, 8'h00, "rnd_unmapped", '0);
             settle("rnd_unmapped_irq");
           end
      endcase
    end

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
